// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: each functional unit queues completions in a small
// FIFO; every cycle up to four queue heads are picked round-robin and
// broadcast on the four registered CDB slots. Slot 2 carries no branch
// decision, so branch completions only use slots 1, 3 and 4.

// Two-entry FIFO for one requester. Pointers are single wrap bits and the
// occupancy is tracked explicitly, so full/empty never depend on pointer compare.
module cdb_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         vld,
  output logic         ready
);
  logic [W-1:0] mem [2];
  logic         wptr, rptr;
  logic [1:0]   cnt;

  // pointer and occupancy update; flush empties the queue outright
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else if (flush) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // storage needs no reset: occupancy decides what is visible
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= din;
  end

  assign dout  = mem[rptr];
  assign vld   = (cnt != 2'd0);
  // ready looks at the count before any same-cycle pop; held low in reset
  assign ready = rst && (cnt != 2'd2);
endmodule

module cdb_arbiter #(
  parameter int NUM_REQ = 6,
  parameter int ROBEN_W = 5   // ROB index bits + 1; ROBEN 0 means "no broadcast"
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       FLUSH_Flag,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ROBEN_W-1:0] req_ROBEN,
  input  logic [NUM_REQ*32-1:0]      req_Write_Data,
  input  logic [NUM_REQ-1:0]         req_is_branch,
  input  logic [NUM_REQ-1:0]         req_Branch_Decision,
  input  logic [NUM_REQ-1:0]         req_EXCEPTION,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [ROBEN_W-1:0]         CDB_ROBEN1,
  output logic [ROBEN_W-1:0]         CDB_ROBEN2,
  output logic [ROBEN_W-1:0]         CDB_ROBEN3,
  output logic [ROBEN_W-1:0]         CDB_ROBEN4,
  output logic [31:0]                CDB_ROBEN1_Write_Data,
  output logic [31:0]                CDB_ROBEN2_Write_Data,
  output logic [31:0]                CDB_ROBEN3_Write_Data,
  output logic [31:0]                CDB_ROBEN4_Write_Data,
  output logic                       CDB_Branch_Decision1,
  output logic                       CDB_Branch_Decision2,
  output logic                       CDB_Branch_Decision3,
  output logic                       CDB_EXCEPTION1,
  output logic                       CDB_EXCEPTION2,
  output logic                       CDB_EXCEPTION3,
  output logic                       CDB_EXCEPTION4
);
  typedef struct packed {
    logic [ROBEN_W-1:0] roben;
    logic [31:0]        data;
    logic               is_branch;
    logic               dec;
    logic               exc;
  } cdb_ent_t;

  localparam int EW    = $bits(cdb_ent_t);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]   NR      = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_RQ = PTR_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0][EW-1:0] din;
  logic [NUM_REQ-1:0][EW-1:0] head;
  logic [NUM_REQ-1:0]         head_vld;
  logic [NUM_REQ-1:0]         push;
  logic [NUM_REQ-1:0]         grant;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] last;
  logic             any;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] sel;
  logic [2:0]       s;
  logic [4:1]       taken;
  cdb_ent_t         e;
  cdb_ent_t [4:1]   slot_ent;
  cdb_ent_t [4:1]   cdb_q;

  // per-lane request packing; ROBEN 0 is handshaken but never stored
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign din[g]  = {req_ROBEN[g*ROBEN_W +: ROBEN_W], req_Write_Data[g*32 +: 32],
                      req_is_branch[g], req_Branch_Decision[g], req_EXCEPTION[g]};
    assign push[g] = req_valid[g] & req_ready[g] & ~FLUSH_Flag &
                     (|req_ROBEN[g*ROBEN_W +: ROBEN_W]);
  end

  cdb_fifo2 #(.W(EW)) u_fifo [NUM_REQ-1:0] (
    .clk   (clk),
    .rst   (rst),
    .flush (FLUSH_Flag),
    .push  (push),
    .pop   (grant),
    .din   (din),
    .dout  (head),
    .vld   (head_vld),
    .ready (req_ready)
  );

  // round-robin scan of queue heads from rr_ptr; each head takes the first
  // free slot it is allowed (non-branch 2,1,3,4; branch 1,3,4) or is skipped
  always_comb begin
    grant    = '0;
    slot_ent = '0;
    taken    = '0;
    last     = '0;
    any      = 1'b0;
    sum      = '0;
    sel      = '0;
    s        = 3'd0;
    e        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= NR) sum = sum - NR;
      sel = sum[PTR_W-1:0];
      e   = cdb_ent_t'(head[sel]);
      s   = 3'd0;
      if (head_vld[sel]) begin
        if (!e.is_branch && !taken[2]) s = 3'd2;
        else if (!taken[1])            s = 3'd1;
        else if (!taken[3])            s = 3'd3;
        else if (!taken[4])            s = 3'd4;
      end
      if (s != 3'd0) begin
        taken[s]        = 1'b1;
        slot_ent[s]     = e;
        slot_ent[s].dec = e.dec & e.is_branch;
        grant[sel]      = 1'b1;
        last            = sel;
        any             = 1'b1;
      end
    end
  end

  // fairness pointer moves just past the last requester served
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            rr_ptr <= '0;
    else if (FLUSH_Flag) rr_ptr <= '0;
    else if (any)        rr_ptr <= (last == LAST_RQ) ? '0 : last + 1'b1;
  end

  // registered broadcast; unused slots are all-zero from slot_ent defaults
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            cdb_q <= '0;
    else if (FLUSH_Flag) cdb_q <= '0;
    else                 cdb_q <= slot_ent;
  end

  assign CDB_ROBEN1 = cdb_q[1].roben;
  assign CDB_ROBEN2 = cdb_q[2].roben;
  assign CDB_ROBEN3 = cdb_q[3].roben;
  assign CDB_ROBEN4 = cdb_q[4].roben;
  assign CDB_ROBEN1_Write_Data = cdb_q[1].data;
  assign CDB_ROBEN2_Write_Data = cdb_q[2].data;
  assign CDB_ROBEN3_Write_Data = cdb_q[3].data;
  assign CDB_ROBEN4_Write_Data = cdb_q[4].data;
  assign CDB_Branch_Decision1  = cdb_q[1].dec;
  assign CDB_Branch_Decision2  = cdb_q[3].dec;
  assign CDB_Branch_Decision3  = cdb_q[4].dec;
  assign CDB_EXCEPTION1 = cdb_q[1].exc;
  assign CDB_EXCEPTION2 = cdb_q[2].exc;
  assign CDB_EXCEPTION3 = cdb_q[3].exc;
  assign CDB_EXCEPTION4 = cdb_q[4].exc;

  // slot 2 has no decision output and is_branch is folded into dec
  logic [4:0] unused_bits;
  assign unused_bits = {cdb_q[1].is_branch, cdb_q[2].is_branch, cdb_q[2].dec,
                        cdb_q[3].is_branch, cdb_q[4].is_branch};
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a queue-based reference model predicts
// every slot and req_ready each cycle; literal checks pin the key scenarios.
module tb_cdb_arbiter;
  localparam int N  = 6;
  localparam int RW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            FLUSH_Flag = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*RW-1:0] req_ROBEN = '0;
  logic [N*32-1:0] req_Write_Data = '0;
  logic [N-1:0]    req_is_branch = '0;
  logic [N-1:0]    req_Branch_Decision = '0;
  logic [N-1:0]    req_EXCEPTION = '0;
  logic [N-1:0]    req_ready;
  logic [RW-1:0]   CDB_ROBEN1, CDB_ROBEN2, CDB_ROBEN3, CDB_ROBEN4;
  logic [31:0]     CDB_ROBEN1_Write_Data, CDB_ROBEN2_Write_Data;
  logic [31:0]     CDB_ROBEN3_Write_Data, CDB_ROBEN4_Write_Data;
  logic            CDB_Branch_Decision1, CDB_Branch_Decision2, CDB_Branch_Decision3;
  logic            CDB_EXCEPTION1, CDB_EXCEPTION2, CDB_EXCEPTION3, CDB_EXCEPTION4;

  cdb_arbiter #(.NUM_REQ(N), .ROBEN_W(RW)) dut (
    .clk(clk), .rst(rst), .FLUSH_Flag(FLUSH_Flag),
    .req_valid(req_valid), .req_ROBEN(req_ROBEN), .req_Write_Data(req_Write_Data),
    .req_is_branch(req_is_branch), .req_Branch_Decision(req_Branch_Decision),
    .req_EXCEPTION(req_EXCEPTION), .req_ready(req_ready),
    .CDB_ROBEN1(CDB_ROBEN1), .CDB_ROBEN2(CDB_ROBEN2),
    .CDB_ROBEN3(CDB_ROBEN3), .CDB_ROBEN4(CDB_ROBEN4),
    .CDB_ROBEN1_Write_Data(CDB_ROBEN1_Write_Data), .CDB_ROBEN2_Write_Data(CDB_ROBEN2_Write_Data),
    .CDB_ROBEN3_Write_Data(CDB_ROBEN3_Write_Data), .CDB_ROBEN4_Write_Data(CDB_ROBEN4_Write_Data),
    .CDB_Branch_Decision1(CDB_Branch_Decision1), .CDB_Branch_Decision2(CDB_Branch_Decision2),
    .CDB_Branch_Decision3(CDB_Branch_Decision3),
    .CDB_EXCEPTION1(CDB_EXCEPTION1), .CDB_EXCEPTION2(CDB_EXCEPTION2),
    .CDB_EXCEPTION3(CDB_EXCEPTION3), .CDB_EXCEPTION4(CDB_EXCEPTION4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  roben;
    logic [31:0] data;
    logic        br;
    logic        dec;
    logic        exc;
  } ent_t;

  ent_t mq [N][$];     // model queues, one per requester
  ent_t exp_slot [5];  // expected slot contents, index 1..4
  int   m_rr;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) mq[i].delete();
    for (int s = 0; s < 5; s++) exp_slot[s] = '{roben: '0, data: '0, br: 1'b0, dec: 1'b0, exc: 1'b0};
    m_rr = 0;
  endtask

  // one clock edge of the reference behaviour, using the pre-edge inputs
  task automatic model_edge();
    int   nb_ord [4] = '{2, 1, 3, 4};
    int   br_ord [3] = '{1, 3, 4};
    bit   used [5];
    bit   rdy [N];
    int   last;
    int   i;
    int   pick;
    ent_t h;
    ent_t ne;
    if (FLUSH_Flag) begin
      model_clear();
      return;
    end
    for (int r = 0; r < N; r++) rdy[r] = (mq[r].size() < 2);
    for (int s = 0; s < 5; s++) begin
      used[s] = 1'b0;
      exp_slot[s] = '{roben: '0, data: '0, br: 1'b0, dec: 1'b0, exc: 1'b0};
    end
    last = -1;
    for (int k = 0; k < N; k++) begin
      i = (m_rr + k) % N;
      if (mq[i].size() == 0) continue;
      h = mq[i][0];
      pick = 0;
      if (h.br) begin
        foreach (br_ord[j]) if (pick == 0 && !used[br_ord[j]]) pick = br_ord[j];
      end else begin
        foreach (nb_ord[j]) if (pick == 0 && !used[nb_ord[j]]) pick = nb_ord[j];
      end
      if (pick != 0) begin
        used[pick] = 1'b1;
        exp_slot[pick] = h;
        void'(mq[i].pop_front());
        last = i;
      end
    end
    if (last >= 0) m_rr = (last + 1) % N;
    for (int r = 0; r < N; r++) begin
      if (req_valid[r] && rdy[r] && req_ROBEN[r*RW +: RW] != 5'd0) begin
        ne.roben = req_ROBEN[r*RW +: RW];
        ne.data  = req_Write_Data[r*32 +: 32];
        ne.br    = req_is_branch[r];
        ne.dec   = req_Branch_Decision[r];
        ne.exc   = req_EXCEPTION[r];
        mq[r].push_back(ne);
      end
    end
  endtask

  function automatic logic [63:0] slot_exp(input int s, input bit has_dec);
    ent_t x;
    x = exp_slot[s];
    return {25'b0, x.roben, x.data, (has_dec ? (x.br & x.dec) : 1'b0), x.exc};
  endfunction

  task automatic compare();
    logic [N-1:0] er;
    for (int r = 0; r < N; r++) er[r] = rst && (mq[r].size() < 2);
    chk("slot1", {25'b0, CDB_ROBEN1, CDB_ROBEN1_Write_Data, CDB_Branch_Decision1, CDB_EXCEPTION1}, slot_exp(1, 1'b1));
    chk("slot2", {25'b0, CDB_ROBEN2, CDB_ROBEN2_Write_Data, 1'b0, CDB_EXCEPTION2}, slot_exp(2, 1'b0));
    chk("slot3", {25'b0, CDB_ROBEN3, CDB_ROBEN3_Write_Data, CDB_Branch_Decision2, CDB_EXCEPTION3}, slot_exp(3, 1'b1));
    chk("slot4", {25'b0, CDB_ROBEN4, CDB_ROBEN4_Write_Data, CDB_Branch_Decision3, CDB_EXCEPTION4}, slot_exp(4, 1'b1));
    chk("ready", {58'b0, req_ready}, {58'b0, er});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    else     model_clear();
    #1;
    compare();
  endtask

  task automatic set_req(input int i, input logic [4:0] rob, input logic [31:0] d,
                         input logic br, input logic dec, input logic exc);
    req_valid[i]              = 1'b1;
    req_ROBEN[i*RW +: RW]     = rob;
    req_Write_Data[i*32 +: 32] = d;
    req_is_branch[i]          = br;
    req_Branch_Decision[i]    = dec;
    req_EXCEPTION[i]          = exc;
  endtask

  task automatic idle();
    req_valid = '0;
  endtask

  function automatic logic [63:0] all_roben();
    return {44'b0, CDB_ROBEN1, CDB_ROBEN2, CDB_ROBEN3, CDB_ROBEN4};
  endfunction

  initial begin
    int rob;
    model_clear();

    // reset held low: everything zero, not ready
    #1;
    compare();
    #11 rst = 1'b1;
    #1;
    chk("lit_rst_ready", {58'b0, req_ready}, 64'h3f);
    tick();

    // single non-branch request lands on slot 2 one edge after acceptance
    set_req(0, 5'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("lit_single_rob2", 64'(CDB_ROBEN2), 64'd3);
    chk("lit_single_data2", 64'(CDB_ROBEN2_Write_Data), 64'hDEAD_BEEF);
    chk("lit_single_others", {49'b0, CDB_ROBEN1, CDB_ROBEN3, CDB_ROBEN4}, 64'd0);
    tick();

    // flush to bring rr_ptr back to 0
    FLUSH_Flag = 1'b1;
    tick();
    FLUSH_Flag = 1'b0;

    // six simultaneous non-branch requests
    for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("lit_six_a", {44'b0, CDB_ROBEN2, CDB_ROBEN1, CDB_ROBEN3, CDB_ROBEN4},
        {44'b0, 5'd1, 5'd2, 5'd3, 5'd4});
    chk("pin_rr_4", 64'(m_rr), 64'd4);
    tick();
    chk("lit_six_b", {44'b0, CDB_ROBEN2, CDB_ROBEN1, CDB_ROBEN3, CDB_ROBEN4},
        {44'b0, 5'd5, 5'd6, 5'd0, 5'd0});
    chk("pin_rr_0", 64'(m_rr), 64'd0);
    tick();

    // four branch requests: slot 2 never used for branches
    set_req(0, 5'd7,  32'h7, 1'b1, 1'b1, 1'b0);
    set_req(1, 5'd8,  32'h8, 1'b1, 1'b0, 1'b0);
    set_req(2, 5'd9,  32'h9, 1'b1, 1'b1, 1'b0);
    set_req(3, 5'd10, 32'hA, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("lit_br_robs", all_roben(), {44'b0, 5'd7, 5'd0, 5'd8, 5'd9});
    chk("lit_br_dec", {61'b0, CDB_Branch_Decision1, CDB_Branch_Decision2, CDB_Branch_Decision3}, 64'b101);
    tick();
    chk("lit_br_tail", {59'b0, CDB_ROBEN1}, 64'd10);
    chk("lit_br_tail_dec", {63'b0, CDB_Branch_Decision1}, 64'd0);

    // mixed traffic: exceptions, a ROBEN-0 discard, branches and non-branches
    set_req(0, 5'd12, 32'h1200, 1'b1, 1'b1, 1'b0);
    set_req(1, 5'd13, 32'h1111, 1'b0, 1'b0, 1'b1);
    set_req(2, 5'd0,  32'hFFFF, 1'b0, 1'b0, 1'b0);
    set_req(3, 5'd14, 32'h1400, 1'b1, 1'b1, 1'b0);
    set_req(4, 5'd15, 32'h1500, 1'b1, 1'b0, 1'b1);
    set_req(5, 5'd16, 32'h1600, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    for (int c = 0; c < 3; c++) tick();

    // back-pressure: steer rr_ptr to 2, then saturate branch slots
    FLUSH_Flag = 1'b1;
    tick();
    FLUSH_Flag = 1'b0;
    set_req(1, 5'd30, 32'h3000, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("pin_rr_2", 64'(m_rr), 64'd2);
    rob = 11;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) begin
        set_req(i, 5'(rob), 32'hB000 + 32'(rob), 1'b1, rob[0], 1'b0);
        rob++;
      end
      tick();
      if (c == 1) chk("lit_bp_ready", {58'b0, req_ready}, 64'b011100);
    end
    idle();
    for (int c = 0; c < 6; c++) tick();
    chk("lit_bp_drained", all_roben(), 64'd0);

    // flush with five entries queued and a same-cycle request
    for (int i = 0; i < 5; i++) set_req(i, 5'(20 + i), 32'h2000 + 32'(i), 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    set_req(5, 5'd25, 32'h2500, 1'b0, 1'b0, 1'b0);
    FLUSH_Flag = 1'b1;
    tick();
    chk("lit_flush_robs", all_roben(), 64'd0);
    chk("lit_flush_ready", {58'b0, req_ready}, 64'h3f);
    FLUSH_Flag = 1'b0;
    idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("lit_flush_quiet", all_roben(), 64'd0);
    end

    // asynchronous reset mid-cycle with entries both broadcasting and queued
    for (int i = 0; i < 3; i++) set_req(i, 5'(1 + i), 32'h4000 + 32'(i), 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) set_req(i, 5'(4 + i), 32'h5000 + 32'(i), 1'b0, 1'b0, 1'b0);
    tick();
    chk("lit_pre_reset", all_roben(), {44'b0, 5'd2, 5'd1, 5'd3, 5'd0});
    idle();
    #3 rst = 1'b0;
    #1;
    chk("lit_areset_robs", all_roben(), 64'd0);
    chk("lit_areset_ready", {58'b0, req_ready}, 64'd0);
    model_clear();
    compare();
    #1 rst = 1'b1;
    set_req(4, 5'd17, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("lit_post_reset", all_roben(), {44'b0, 5'd0, 5'd17, 5'd0, 5'd0});
    chk("lit_post_reset_data", 64'(CDB_ROBEN2_Write_Data), 64'hCAFE_F00D);
    tick();
    tick();
    chk("lit_post_reset_quiet", all_roben(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 6, the number of functional-unit completion requesters.
REQ-002 SHALL have parameter ROBEN_W, default `ROB_SIZE_bits+1 (5), the ROBEN width; ROBEN 0 means no broadcast.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- FLUSH_Flag  in  1  pipeline flush from commit
- req_valid  in  NUM_REQ  completion request per unit
- req_ROBEN  in  NUM_REQ*ROBEN_W  ROB entry being completed
- req_Write_Data  in  NUM_REQ*32  result value
- req_is_branch  in  NUM_REQ  request carries a branch decision
- req_Branch_Decision  in  NUM_REQ  branch taken/not-taken
- req_EXCEPTION  in  NUM_REQ  exception raised
- req_ready  out  NUM_REQ  per-requester queue can accept
- CDB_ROBEN1..4  out  ROBEN_W each  broadcast ROBEN per slot
- CDB_ROBEN1..4_Write_Data  out  32 each  broadcast value
- CDB_Branch_Decision1/2/3  out  1 each  decisions for slots 1/3/4
- CDB_EXCEPTION1..4  out  1 each  exception per slot

Function
REQ-005 SHALL hold a 2-entry FIFO per requester storing {ROBEN, data, is_branch, decision, exception}.
REQ-006 SHALL assert req_ready[i] when FIFO i holds fewer than 2 entries (count before same-cycle dequeue; no full-bypass).
REQ-007 SHALL enqueue on rising edge when req_valid[i] & req_ready[i] & ~FLUSH_Flag; requests with ROBEN 0 are accepted and discarded.
REQ-008 SHALL never grant an entry in its enqueue cycle; earliest CDB appearance is the edge after acceptance (1-cycle latency).
REQ-009 SHALL each cycle scan FIFO heads round-robin from rr_ptr, granting at most 4 entries, at most one per requester.
REQ-010 SHALL place non-branch entries in the first free of slots 2,1,3,4; branch entries in the first free of slots 1,3,4 (never slot 2).
REQ-011 SHALL skip (not stall on) a branch head when slots 1,3,4 are taken; scanning continues for non-branch heads.
REQ-012 SHALL advance rr_ptr to (last granted requester + 1) mod NUM_REQ; rr_ptr unchanged when nothing granted.
REQ-013 SHALL register all CDB outputs; an unused slot drives ROBEN 0, data 0, decision 0, exception 0.
REQ-014 SHALL dequeue exactly the granted heads on the same edge the CDB registers load them.
REQ-015 SHALL on FLUSH_Flag high at a rising edge clear all FIFOs, zero all CDB outputs, reset rr_ptr to 0, and drop same-cycle requests.
REQ-016 SHALL never broadcast the same FIFO entry twice nor lose an accepted non-zero-ROBEN entry absent flush/reset.
REQ-017 SHALL keep FIFO pointers as 1-bit wrap with explicit count; wrap-around on entry 1->0 preserves order.

Reset
REQ-018 SHALL on rst low immediately clear FIFO counts/pointers, rr_ptr=0, all CDB outputs 0, req_ready all 1 once rst released (req_ready 0 while rst low).
REQ-019 SHALL abandon in-flight entries on mid-operation reset; first post-reset broadcast only from requests accepted after release.

Verification
REQ-020 Single request: req0 ROBEN=3, data=0xDEAD_BEEF, non-branch, accepted edge t -> edge t+1 CDB_ROBEN2=3, data 0xDEADBEEF, slots 1/3/4 ROBEN 0.
REQ-021 Six simultaneous non-branch requests ROBEN 1..6, rr_ptr=0 -> next edge slots 2,1,3,4 = 1,2,3,4; following edge slots 2,1 = 5,6; rr_ptr=4 then 0.
REQ-022 Four branch requests (req0..3, ROBEN 7..10, decisions 1,0,1,0) -> slots 1,3,4 = 7,8,9 with decisions 1,0,1; slot 2 ROBEN 0; ROBEN 10 next cycle on slot 1 decision 0.
REQ-023 Back-pressure: req1 held valid 3 cycles with no grants possible (slots saturated) -> req_ready[1] drops after 2 accepts; no entry lost, order preserved.
REQ-024 Flush: FIFOs holding 5 entries, FLUSH_Flag pulsed -> next edge all CDB ROBEN 0, all req_ready 1, no stale broadcast afterwards.
REQ-025 Async reset: rst driven low mid-cycle with 3 queued entries -> outputs 0 before next edge; after release, only new requests broadcast.
